// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA launch controller: state encoding and the
// default cycle-counter width.
package cgra_pkg;

  localparam int CGRA_CWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ABORT   = 2'd3
  } cgra_state_e;

endpackage : cgra_pkg

// File: rtl/cgra_launch_ctrl.sv
// Launch controller for one CGRA computation: start/done handshake with the
// wrapper, timeout and abort handling, sticky status flags and latency capture.
module cgra_launch_ctrl
  import cgra_pkg::*;
#(
  parameter int CWIDTH = CGRA_CWIDTH
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Host_Start,
  input  logic              Host_Abort,
  input  logic              Host_Irq_Clear,
  input  logic [CWIDTH-1:0] Timeout_Limit,
  output logic              Computation_Start,
  input  logic              Computation_Done,
  output logic              Busy,
  output logic              Done_Irq,
  output logic              Timeout_Err,
  output logic [CWIDTH-1:0] Run_Cycles
);

  localparam logic [CWIDTH-1:0] ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

  cgra_state_e       state_q, state_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d, cnt_inc, run_d;
  logic              start_d, busy_d, irq_d, err_d;
  logic              irq_set, err_set, timeout_hit;

  // The counter sticks at all-ones so a very long launch reports the maximum.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + ONE;
  assign timeout_hit = (Timeout_Limit != '0) && (cnt_q == Timeout_Limit - ONE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = Run_Cycles;
    start_d = Computation_Start;
    irq_set = 1'b0;
    err_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Host_Start) begin
          if (Computation_Done) begin
            err_set = 1'b1;
          end else begin
            state_d = ST_RUN;
            start_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // Done is checked first so it wins over a coincident timeout or abort.
        if (Computation_Done) begin
          run_d   = cnt_inc;
          start_d = 1'b0;
          irq_set = 1'b1;
          state_d = ST_RELEASE;
        end else if (Host_Abort || timeout_hit) begin
          start_d = 1'b0;
          err_set = 1'b1;
          state_d = ST_ABORT;
        end
      end
      ST_RELEASE, ST_ABORT: begin
        start_d = 1'b0;
        if (!Computation_Done) state_d = ST_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A set event in the same cycle as a clear leaves the flag set.
    irq_d  = irq_set | (Done_Irq    & ~Host_Irq_Clear);
    err_d  = err_set | (Timeout_Err & ~Host_Irq_Clear);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      Computation_Start <= 1'b0;
      Busy              <= 1'b0;
      Done_Irq          <= 1'b0;
      Timeout_Err       <= 1'b0;
      Run_Cycles        <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      Computation_Start <= start_d;
      Busy              <= busy_d;
      Done_Irq          <= irq_d;
      Timeout_Err       <= err_d;
      Run_Cycles        <= run_d;
    end
  end

endmodule : cgra_launch_ctrl

// File: tb/tb_cgra_launch_ctrl.sv
// Self-checking bench for cgra_launch_ctrl: directed scenarios plus randomized
// launches checked against a transaction-level model of the launch outcome.
module tb_cgra_launch_ctrl;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Resetn = 1'b0;
  logic         Host_Start = 1'b0;
  logic         Host_Abort = 1'b0;
  logic         Host_Irq_Clear = 1'b0;
  logic         Computation_Done = 1'b0;
  logic [W-1:0] Timeout_Limit = '0;
  logic         Computation_Start, Busy, Done_Irq, Timeout_Err;
  logic [W-1:0] Run_Cycles;

  logic [3:0]   limit4 = 4'd0;
  logic         start4, busy4, irq4, err4;
  logic [3:0]   run4;

  int vectors = 0;
  int miscompares = 0;

  // Model state: sticky flags and last reported latency.
  logic         exp_irq = 1'b0;
  logic         exp_err = 1'b0;
  logic [W-1:0] exp_run = '0;

  cgra_launch_ctrl #(.CWIDTH(W)) dut (
    .Clk(Clk), .Resetn(Resetn), .Host_Start(Host_Start), .Host_Abort(Host_Abort),
    .Host_Irq_Clear(Host_Irq_Clear), .Timeout_Limit(Timeout_Limit),
    .Computation_Start(Computation_Start), .Computation_Done(Computation_Done),
    .Busy(Busy), .Done_Irq(Done_Irq), .Timeout_Err(Timeout_Err), .Run_Cycles(Run_Cycles)
  );

  cgra_launch_ctrl #(.CWIDTH(4)) dut4 (
    .Clk(Clk), .Resetn(Resetn), .Host_Start(Host_Start), .Host_Abort(Host_Abort),
    .Host_Irq_Clear(Host_Irq_Clear), .Timeout_Limit(limit4),
    .Computation_Start(start4), .Computation_Done(Computation_Done),
    .Busy(busy4), .Done_Irq(irq4), .Timeout_Err(err4), .Run_Cycles(run4)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_flags(input string name);
    vectors++;
    if (Done_Irq !== exp_irq || Timeout_Err !== exp_err || Run_Cycles !== exp_run) begin
      miscompares++;
      $display("FAIL %s flags: got irq=%b err=%b run=%0d, want irq=%b err=%b run=%0d",
               name, Done_Irq, Timeout_Err, Run_Cycles, exp_irq, exp_err, exp_run);
    end
  endtask

  task automatic clear_flags();
    Host_Irq_Clear = 1'b1;
    step();
    Host_Irq_Clear = 1'b0;
    exp_irq = 1'b0;
    exp_err = 1'b0;
    check_flags("irq_clear");
  endtask

  // One launch. k: edge (relative to Start rise) at which Done is sampled high;
  // lim: timeout limit; abort_at: edge at which Host_Abort is sampled (0 = none);
  // hold: extra cycles Done stays high; spam: Host_Start held high throughout.
  task automatic launch(input string name, input int k, input int lim,
                        input int abort_at, input int hold, input bit spam);
    int  end_i;
    bit  done_wins;
    end_i = k;
    if (lim != 0 && lim < end_i) end_i = lim;
    if (abort_at != 0 && abort_at < end_i) end_i = abort_at;
    done_wins = (end_i == k);

    Timeout_Limit = W'(lim);
    Host_Start = 1'b1;
    step();
    Host_Start = spam;
    vectors++;
    if (Computation_Start !== 1'b1 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s launch: got start=%b busy=%b, want 1 1", name, Computation_Start, Busy);
    end

    for (int i = 1; i <= end_i; i++) begin
      Computation_Done = (i == k);
      Host_Abort       = (i == abort_at);
      step();
      vectors++;
      if (Computation_Start !== (i < end_i) || Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s run cycle %0d: got start=%b busy=%b, want start=%b busy=1",
                 name, i, Computation_Start, Busy, (i < end_i));
      end
    end
    Host_Abort = 1'b0;

    if (done_wins) begin
      exp_irq = 1'b1;
      exp_run = W'(k);
    end else begin
      exp_err = 1'b1;
    end
    check_flags(name);

    if (done_wins) begin
      for (int j = 0; j < hold; j++) begin
        step();
        vectors++;
        if (Computation_Start !== 1'b0 || Busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s release hold %0d: got start=%b busy=%b, want 0 1",
                   name, j, Computation_Start, Busy);
        end
      end
    end
    Computation_Done = 1'b0;
    step();
    Host_Start = 1'b0;
    vectors++;
    if (Busy !== 1'b0 || Computation_Start !== 1'b0) begin
      miscompares++;
      $display("FAIL %s return idle: got busy=%b start=%b, want 0 0", name, Busy, Computation_Start);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    step();
    vectors++;
    if (Computation_Start !== 1'b0 || Busy !== 1'b0 || Done_Irq !== 1'b0 ||
        Timeout_Err !== 1'b0 || Run_Cycles !== '0) begin
      miscompares++;
      $display("FAIL reset: got start=%b busy=%b irq=%b err=%b run=%0d, want all 0",
               Computation_Start, Busy, Done_Irq, Timeout_Err, Run_Cycles);
    end
    Resetn = 1'b1;
    step();
    check_flags("after_reset");
  endtask

  task automatic test_saturation();
    launch("saturation", 20, 0, 0, 0, 1'b0);
    vectors++;
    if (run4 !== 4'd15 || irq4 !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation cwidth4: got run=%0d irq=%b, want run=15 irq=1", run4, irq4);
    end
  endtask

  task automatic test_normal();
    launch("normal", 37, 0, 0, 2, 1'b0);
  endtask

  task automatic test_timeout();
    clear_flags();
    launch("timeout", 1000, 10, 0, 0, 1'b0);
    clear_flags();
    launch("timeout_collision", 6, 6, 0, 1, 1'b0);
    launch("timeout_limit1", 1000, 1, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    clear_flags();
    launch("abort", 1000, 0, 5, 0, 1'b0);
    clear_flags();
    launch("abort_collision", 8, 0, 8, 0, 1'b0);
  endtask

  task automatic test_ignored_starts();
    clear_flags();
    launch("spam_start", 12, 0, 0, 3, 1'b1);
    step();
    vectors++;
    if (Busy !== 1'b0 || Computation_Start !== 1'b0) begin
      miscompares++;
      $display("FAIL no_queued_launch: got busy=%b start=%b, want 0 0", Busy, Computation_Start);
    end
    Computation_Done = 1'b1;
    Host_Start = 1'b1;
    step();
    Host_Start = 1'b0;
    exp_err = 1'b1;
    vectors++;
    if (Busy !== 1'b0 || Computation_Start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_while_done: got busy=%b start=%b, want 0 0", Busy, Computation_Start);
    end
    check_flags("start_while_done");
    // Clear and set in the same cycle: the set wins.
    Host_Start = 1'b1;
    Host_Irq_Clear = 1'b1;
    step();
    Host_Start = 1'b0;
    Host_Irq_Clear = 1'b0;
    Computation_Done = 1'b0;
    exp_irq = 1'b0;
    check_flags("clear_vs_set");
    step();
  endtask

  task automatic test_reset_mid_run();
    Timeout_Limit = '0;
    Host_Start = 1'b1;
    step();
    Host_Start = 1'b0;
    step();
    step();
    step();
    Resetn = 1'b0;
    #1;
    vectors++;
    if (Computation_Start !== 1'b0 || Busy !== 1'b0 || Done_Irq !== 1'b0 ||
        Timeout_Err !== 1'b0 || Run_Cycles !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run async: got start=%b busy=%b irq=%b err=%b run=%0d, want all 0",
               Computation_Start, Busy, Done_Irq, Timeout_Err, Run_Cycles);
    end
    exp_irq = 1'b0;
    exp_err = 1'b0;
    exp_run = '0;
    step();
    Resetn = 1'b1;
    step();
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run idle: got busy=%b, want 0", Busy);
    end
    launch("relaunch_after_reset", 5, 0, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    int k, lim, ab, hold;
    for (int n = 0; n < 25; n++) begin
      k    = int'($urandom_range(1, 40));
      lim  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 45));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : 0;
      hold = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) clear_flags();
      launch($sformatf("random%0d", n), k, lim, ab, hold, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_normal();
    test_timeout();
    test_abort();
    test_ignored_starts();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cgra_launch_ctrl

// File: doc/cgra_launch_ctrl.md
CGRA_LAUNCH_CTRL -- requirements
Module: cgra_launch_ctrl

Interface
REQ-001 Parameter CWIDTH, default 32, width of the cycle counter, timeout limit and measured-latency output.
REQ-002 Clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Host_Start  input  1  one-cycle launch request from the software register bank.
REQ-005 Host_Abort  input  1  one-cycle abort request.
REQ-006 Host_Irq_Clear  input  1  one-cycle clear of Done_Irq and Timeout_Err.
REQ-007 Timeout_Limit  input  CWIDTH  maximum cycles allowed in RUN; 0 disables the timeout.
REQ-008 Computation_Start  output  1  level start to the CGRA wrapper, registered.
REQ-009 Computation_Done  input  1  level done from the CGRA wrapper, synchronous to Clk.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 Done_Irq  output  1  sticky flag for a completed launch.
REQ-012 Timeout_Err  output  1  sticky flag for a timeout or an abort.
REQ-013 Run_Cycles  output  CWIDTH  latency of the last launch, from Computation_Start rise to Computation_Done rise.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, RELEASE and ABORT.
REQ-015 IDLE: when Host_Start=1 and Computation_Done=0, the FSM SHALL go to RUN, set Computation_Start=1 on the next edge, and clear the counter.
REQ-016 IDLE: when Host_Start=1 and Computation_Done=1, the block SHALL ignore the request, stay in IDLE and set Timeout_Err.
REQ-017 RUN: the counter SHALL increment by 1 each cycle and saturate at all-ones.
REQ-018 RUN, on Computation_Done=1: the block SHALL latch the counter into Run_Cycles, drop Computation_Start, set Done_Irq and go to RELEASE.
  - Latency: Start rising at edge N and Done sampled high at edge N+k gives Run_Cycles=k.
REQ-019 RUN: when Timeout_Limit!=0 and counter==Timeout_Limit-1 with Done=0, or when Host_Abort=1, the block SHALL drop Computation_Start, set Timeout_Err and go to ABORT.
REQ-020 When Done=1 coincides with a timeout or an abort, Done SHALL win and REQ-018 SHALL apply.
REQ-021 RELEASE and ABORT SHALL return to IDLE in the cycle after Computation_Done is sampled 0; Computation_Start SHALL stay 0 in both states.
REQ-022 Host_Start received while Busy=1 SHALL be ignored, with no queuing.
REQ-023 Host_Abort in IDLE, RELEASE or ABORT SHALL have no effect.
REQ-024 Host_Irq_Clear SHALL clear both sticky flags; when a set event occurs in the same cycle, the set SHALL win.
REQ-025 Run_Cycles SHALL hold its value until the next successful completion, and SHALL NOT update on abort or timeout.

Reset
REQ-026 Resetn=0 SHALL immediately force IDLE and set Computation_Start, Busy, Done_Irq, Timeout_Err, Run_Cycles and the counter to 0.
REQ-027 Reset mid-launch SHALL drop Computation_Start asynchronously.
  - After release, the block SHALL wait in IDLE.
  - The REQ-016 guard SHALL block relaunch while Computation_Done is still high.

Structure
REQ-028 The state encoding SHALL be a typedef in the shared package cgra_pkg, together with the constant CGRA_CWIDTH=32.
REQ-029 The block SHALL be flat, with no sub-modules; the counter and FSM SHALL be in one module.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Normal launch: Host_Start pulse; Done rises 37 cycles after Start and falls 2 cycles after Start drops -> Run_Cycles=37, Done_Irq=1, Busy=0 one cycle after Done falls.
REQ-032 Timeout: Timeout_Limit=10, Done held 0 -> Start drops after 10 RUN cycles, Timeout_Err=1, Done_Irq=0, Run_Cycles unchanged.
REQ-033 Abort plus collision: Host_Abort on cycle 5 of RUN -> ABORT, Timeout_Err=1. Repeat with Host_Abort on the same cycle as Done=1 -> Done_Irq=1, Timeout_Err=0.
REQ-034 Ignored starts: Host_Start pulses in RUN and RELEASE -> no second launch. Host_Start in IDLE with Done=1 -> no launch and Timeout_Err=1.
REQ-035 Saturation: CWIDTH=4, Timeout_Limit=0, Done after 20 cycles -> Run_Cycles=15.
REQ-036 Reset mid-RUN: Resetn pulled low on cycle 3 of RUN -> Start=0 before the next edge, all outputs 0. After release, Host_Start with Done=0 launches normally.
